// File: rtl/ist_mem_arbiter.sv
// Round-robin arbiter sharing one IST memory request/response stream pair between
// NUM_REQ traversal units; in-order responses are routed back through a tag FIFO.

`ifndef IST_MEM_REQ_WIDTH
`define IST_MEM_REQ_WIDTH 32
`endif
`ifndef IST_MEM_RESP_WIDTH
`define IST_MEM_RESP_WIDTH 16
`endif

module ist_mem_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                      clk,
    input  logic                                      arst_n,
    input  logic [NUM_REQ-1:0]                        req_empty_n,
    output logic [NUM_REQ-1:0]                        req_read,
    input  logic [NUM_REQ*`IST_MEM_REQ_WIDTH-1:0]     req_dout,
    input  logic                                      ist_mem_req_stream_full_n,
    output logic                                      ist_mem_req_stream_write,
    output logic [`IST_MEM_REQ_WIDTH-1:0]             ist_mem_req_stream_din,
    input  logic                                      ist_mem_resp_stream_empty_n,
    output logic                                      ist_mem_resp_stream_read,
    input  logic [`IST_MEM_RESP_WIDTH-1:0]            ist_mem_resp_stream_dout,
    input  logic [NUM_REQ-1:0]                        resp_full_n,
    output logic [NUM_REQ-1:0]                        resp_write,
    output logic [NUM_REQ*`IST_MEM_RESP_WIDTH-1:0]    resp_din,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding,
    output logic                                      err
);

    localparam int REQ_W  = `IST_MEM_REQ_WIDTH;
    localparam int RESP_W = `IST_MEM_RESP_WIDTH;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] tag_mem_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             err_r;

    logic             found_s;
    logic [IDX_W-1:0] winner_s;
    logic [IDX_W-1:0] rr_next_s;
    logic [IDX_W-1:0] head_tag_s;
    logic             issue_ok_s;
    logic             push_s;
    logic             pop_s;

    // Round-robin winner search starting at rr_ptr_r.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int idx;
            idx = (int'(rr_ptr_r) + off) % NUM_REQ;
            if (!found_s && req_empty_n[idx]) begin
                found_s  = 1'b1;
                winner_s = IDX_W'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Issue/return enables; push eligibility deliberately uses the pre-pop count.
    always_comb begin
        head_tag_s = tag_mem_r[head_r];
        issue_ok_s = ist_mem_req_stream_full_n && (count_r < CNT_W'(MAX_OUTSTANDING));
        push_s     = issue_ok_s && found_s;
        pop_s      = ist_mem_resp_stream_empty_n && (count_r != CNT_W'(0))
                     && resp_full_n[head_tag_s];
        if (winner_s == IDX_W'(NUM_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = winner_s + IDX_W'(1);
        end
    end

    // Stream handshakes and data steering.
    always_comb begin
        req_read                 = '0;
        ist_mem_req_stream_write = 1'b0;
        ist_mem_req_stream_din   = '0;
        ist_mem_resp_stream_read = 1'b0;
        resp_write               = '0;
        resp_din                 = {NUM_REQ{ist_mem_resp_stream_dout}};
        if (push_s) begin
            req_read                 = NUM_REQ'(1) << winner_s;
            ist_mem_req_stream_write = 1'b1;
            ist_mem_req_stream_din   = req_dout[int'(winner_s)*REQ_W +: REQ_W];
        end else begin
            req_read                 = '0;
        end
        if (pop_s) begin
            ist_mem_resp_stream_read = 1'b1;
            resp_write               = NUM_REQ'(1) << head_tag_s;
        end else begin
            resp_write               = '0;
        end
    end

    // Arbitration pointer, tag FIFO pointers/occupancy and sticky error.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rr_ptr_r <= '0;
            head_r   <= '0;
            tail_r   <= '0;
            count_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            if (push_s) begin
                rr_ptr_r <= rr_next_s;
                tail_r   <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (ist_mem_resp_stream_empty_n && (count_r == CNT_W'(0))) begin
                err_r <= 1'b1;
            end
        end
    end

    // Tag storage: requester index of each issued request, in issue order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_mem_r[i] <= '0;
            end
        end else if (push_s) begin
            tag_mem_r[tail_r] <= winner_s;
        end
    end

    assign outstanding = count_r;
    assign err         = err_r;

    logic unused_s;
    assign unused_s = &{1'b0, RESP_W[0]};

endmodule

// File: tb/tb_ist_mem_arbiter.sv
// Directed self-checking bench for ist_mem_arbiter (NUM_REQ=2, MAX_OUTSTANDING=4).

`ifndef IST_MEM_REQ_WIDTH
`define IST_MEM_REQ_WIDTH 32
`endif
`ifndef IST_MEM_RESP_WIDTH
`define IST_MEM_RESP_WIDTH 16
`endif

module tb_ist_mem_arbiter;

    localparam int NR  = 2;
    localparam int MO  = 4;
    localparam int RQW = `IST_MEM_REQ_WIDTH;
    localparam int RSW = `IST_MEM_RESP_WIDTH;
    localparam int CW  = $clog2(MO + 1);

    logic                clk = 1'b0;
    logic                arst_n;
    logic [NR-1:0]       req_empty_n;
    logic [NR-1:0]       req_read;
    logic [NR*RQW-1:0]   req_dout;
    logic                full_n;
    logic                mwrite;
    logic [RQW-1:0]      mdin;
    logic                rempty_n;
    logic                rread;
    logic [RSW-1:0]      rdout;
    logic [NR-1:0]       resp_full_n;
    logic [NR-1:0]       resp_write;
    logic [NR*RSW-1:0]   resp_din;
    logic [CW-1:0]       outstanding;
    logic                err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0]  g_tab [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] r_tab [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
    logic [1:0]  w_tab [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

    ist_mem_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(MO)) dut (
        .clk                         (clk),
        .arst_n                      (arst_n),
        .req_empty_n                 (req_empty_n),
        .req_read                    (req_read),
        .req_dout                    (req_dout),
        .ist_mem_req_stream_full_n   (full_n),
        .ist_mem_req_stream_write    (mwrite),
        .ist_mem_req_stream_din      (mdin),
        .ist_mem_resp_stream_empty_n (rempty_n),
        .ist_mem_resp_stream_read    (rread),
        .ist_mem_resp_stream_dout    (rdout),
        .resp_full_n                 (resp_full_n),
        .resp_write                  (resp_write),
        .resp_din                    (resp_din),
        .outstanding                 (outstanding),
        .err                         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #2;
        arst_n = 1'b1;
        tick();
    endtask

    initial begin
        arst_n      = 1'b0;
        req_empty_n = '0;
        req_dout    = '0;
        full_n      = 1'b1;
        rempty_n    = 1'b0;
        rdout       = '0;
        resp_full_n = 2'b11;
        #3;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err",         64'(err),         64'd0);
        chk("rst_rread",       64'(rread),       64'd0);
        chk("rst_resp_write",  64'(resp_write),  64'd0);
        chk("rst_req_read",    64'(req_read),    64'd0);
        chk("rst_mwrite",      64'(mwrite),      64'd0);
        #4;
        arst_n = 1'b1;
        tick();

        // Requester 0 alone, three back-to-back issues
        req_empty_n = 2'b01;
        for (int k = 0; k < 3; k++) begin
            req_dout = {32'hDEAD_0000, 32'hA000_0000 + 32'(k)};
            #2;
            chk("t1_mwrite",   64'(mwrite),   64'd1);
            chk("t1_req_read", 64'(req_read), 64'h1);
            chk("t1_din",      64'(mdin),     64'hA000_0000 + 64'(k));
            tick();
            chk("t1_outstanding", 64'(outstanding), 64'(k + 1));
        end
        req_empty_n = 2'b00;
        #2;
        chk("t1_idle_mwrite", 64'(mwrite), 64'd0);

        // Alternating grants then full-at-MAX_OUTSTANDING
        do_reset();
        req_empty_n = 2'b11;
        for (int k = 0; k < 4; k++) begin
            req_dout = {32'hB100_0000 + 32'(k), 32'hB000_0000 + 32'(k)};
            #2;
            chk("t2_req_read", 64'(req_read), 64'(g_tab[k]));
            chk("t2_din", 64'(mdin), (k % 2 == 0) ? 64'hB000_0000 + 64'(k) : 64'hB100_0000 + 64'(k));
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("t3_full_mwrite",   64'(mwrite),      64'd0);
            chk("t3_full_req_read", 64'(req_read),    64'd0);
            chk("t3_outstanding",   64'(outstanding), 64'd4);
            tick();
        end
        rempty_n = 1'b1;
        rdout    = r_tab[0];
        #2;
        chk("t3_pop_rread",      64'(rread),      64'd1);
        chk("t3_pop_resp_write", 64'(resp_write), 64'h1);
        chk("t3_pop_resp_din",   64'(resp_din),   64'({2{16'd10}}));
        chk("t3_pop_no_issue",   64'(mwrite),     64'd0);
        tick();
        rempty_n = 1'b0;
        chk("t3_after_pop_outstanding", 64'(outstanding), 64'd3);
        #2;
        chk("t3_reissue_mwrite",   64'(mwrite),   64'd1);
        chk("t3_reissue_req_read", 64'(req_read), 64'h1);
        tick();
        chk("t3_refill_outstanding", 64'(outstanding), 64'd4);
        req_empty_n = 2'b00;
        // Remaining tags are 1,0,1,0
        for (int k = 0; k < 4; k++) begin
            rempty_n = 1'b1;
            rdout    = r_tab[k] + 16'd10;
            #2;
            chk("t2_route_resp_write", 64'(resp_write), 64'(w_tab[k]));
            chk("t2_route_rread",      64'(rread),      64'd1);
            tick();
        end
        rempty_n = 1'b0;
        chk("t2_drained", 64'(outstanding), 64'd0);
        chk("t2_no_err",  64'(err),         64'd0);

        // Head-of-line blocking on requester 1
        do_reset();
        req_empty_n = 2'b10;
        #2;
        chk("t4_issue_r1", 64'(req_read), 64'h2);
        tick();
        req_empty_n = 2'b00;
        rempty_n    = 1'b1;
        rdout       = 16'h0055;
        resp_full_n = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("t4_blocked_rread",      64'(rread),      64'd0);
            chk("t4_blocked_resp_write", 64'(resp_write), 64'd0);
            tick();
            chk("t4_blocked_outstanding", 64'(outstanding), 64'd1);
        end
        resp_full_n = 2'b11;
        #2;
        chk("t4_release_rread",      64'(rread),      64'd1);
        chk("t4_release_resp_write", 64'(resp_write), 64'h2);
        tick();
        rempty_n = 1'b0;
        chk("t4_release_outstanding", 64'(outstanding), 64'd0);

        // Orphan response sets sticky err
        rempty_n = 1'b1;
        rdout    = 16'h0099;
        #2;
        chk("t5_orphan_rread", 64'(rread), 64'd0);
        tick();
        rempty_n = 1'b0;
        chk("t5_err_set", 64'(err), 64'd1);
        tick();
        chk("t5_err_sticky", 64'(err), 64'd1);
        arst_n = 1'b0;
        #1;
        chk("t5_rst_err", 64'(err), 64'd0);
        chk("t5_rst_outstanding", 64'(outstanding), 64'd0);
        arst_n = 1'b1;
        tick();

        // Mid-operation async reset with two outstanding, rr_ptr at 1
        req_empty_n = 2'b01;
        tick();
        tick();
        chk("t6_two_outstanding", 64'(outstanding), 64'd2);
        req_empty_n = 2'b11;
        #1;
        chk("t6_pre_rst_req_read", 64'(req_read), 64'h2);
        arst_n = 1'b0;
        #1;
        chk("t6_rst_outstanding", 64'(outstanding), 64'd0);
        chk("t6_rst_req_read",    64'(req_read),    64'h1);
        chk("t6_rst_rread",       64'(rread),       64'd0);
        arst_n = 1'b1;
        req_empty_n = 2'b00;
        tick();
        chk("t6_post_outstanding", 64'(outstanding), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ist_mem_arbiter.md
# ist_mem_arbiter

Shares the single IST memory request/response stream pair between NUM_REQ traversal units. Requests are granted round-robin and forwarded unchanged. The requester index of each issued request is recorded in an in-order tag FIFO. The memory returns responses strictly in request order, so each response is routed back to the requester at the FIFO head. The block sits between the per-unit IST request/response FIFOs and the IST memory (trig_sram fill engine).

## Interface

- NUM_REQ, 2, number of requesters (2..8)
- MAX_OUTSTANDING, 4, tag FIFO depth; caps in-flight requests (power of two, 2..16)
- clk  in  1  clock; all state updates on rising edge
- arst_n  in  1  asynchronous, active-low reset
- req_empty_n  in  NUM_REQ  per-requester request FIFO non-empty
- req_read  out  NUM_REQ  pop of requester i's request FIFO (one-hot or zero)
- req_dout  in  NUM_REQ*`IST_MEM_REQ_WIDTH  requester i's request at [i*`IST_MEM_REQ_WIDTH +: `IST_MEM_REQ_WIDTH]
- ist_mem_req_stream_full_n  in  1  memory request FIFO can accept
- ist_mem_req_stream_write  out  1  push to memory request FIFO
- ist_mem_req_stream_din  out  `IST_MEM_REQ_WIDTH  granted request, bit-identical to source
- ist_mem_resp_stream_empty_n  in  1  memory response available
- ist_mem_resp_stream_read  out  1  pop of memory response
- ist_mem_resp_stream_dout  in  `IST_MEM_RESP_WIDTH  response (rid)
- resp_full_n  in  NUM_REQ  requester i's response FIFO can accept
- resp_write  out  NUM_REQ  push to requester i's response FIFO (one-hot or zero)
- resp_din  out  NUM_REQ*`IST_MEM_RESP_WIDTH  response replicated to all slices; only the written slice is meaningful
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current tag FIFO occupancy
- err  out  1  sticky: response seen with no outstanding tag

## Operation

- State:
  - rr_ptr: next-priority requester
  - tag FIFO: MAX_OUTSTANDING entries × $clog2(NUM_REQ) bits, head/tail pointers, count
  - err flag
- Issue path (combinational from registered state):
  - issue_ok = ist_mem_req_stream_full_n && (count < MAX_OUTSTANDING).
  - Winner = first i with req_empty_n[i], scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - If issue_ok and a winner exists: req_read[winner]=1, ist_mem_req_stream_write=1, din=winner's slice, push winner index at tail.
  - rr_ptr <= (winner+1) mod NUM_REQ on an issue, else unchanged.
- Return path:
  - If ist_mem_resp_stream_empty_n, count>0 and resp_full_n[head_tag]: ist_mem_resp_stream_read=1, resp_write[head_tag]=1, pop head.
  - If the head requester is full, the response waits. There is no reordering and no bypass to other requesters (head-of-line blocking is intended).
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Push eligibility uses pre-pop count, so at count==MAX_OUTSTANDING no issue occurs even if a pop happens that cycle.
- Pointers wrap modulo MAX_OUTSTANDING.
- Error: ist_mem_resp_stream_empty_n with count==0 sets err (sticky until reset). The response is not read.
- No-activity invariants: every read/write output is 0 whenever its enable condition is false. din is don't-care when write=0.

## Timing

- Reset (arst_n low, async): rr_ptr=0, head=tail=count=0, err=0. Hence outstanding=0 and ist_mem_resp_stream_read=0, resp_write=0. req_read/ist_mem_req_stream_write are 0 unless a request is pending with full_n high.
- Reset mid-operation: in-flight tags are discarded. The surrounding memory must be reset together.
- Issue latency: 0 cycles (same-cycle FIFO-to-FIFO). Throughput: one issue per cycle.
- Return latency: 0 cycles. Throughput: one response per cycle, concurrent with issue.
- outstanding reflects registered count (updates the cycle after push/pop).
- err asserts the cycle after the offending condition.

## Test plan

- Reset, then requester 0 holds 3 requests, memory always ready -> 3 consecutive ist_mem_req_stream_write cycles, din equals requester 0's data, req_read=0b01 each cycle, outstanding goes 1,2,3.
- NUM_REQ=2, both requesters continuously non-empty -> grants alternate 0,1,0,1 starting from 0. Responses (rids 10,20,30,40) are routed as resp_write 0b01,0b10,0b01,0b10.
- Memory never responds, MAX_OUTSTANDING=4, requesters always pending -> exactly 4 issues, then ist_mem_req_stream_write stays 0 and outstanding=4. One response at count 4 -> pop, next cycle one issue.
- Head tag=1, resp_full_n[1]=0 for 5 cycles with response pending -> ist_mem_resp_stream_read=0 for those cycles, no resp_write. Release -> delivered to requester 1 next cycle.
- Response asserted with outstanding=0 -> ist_mem_resp_stream_read stays 0, err=1 next cycle and stays 1. Async reset clears err and outstanding.
- arst_n pulsed low between clock edges with 2 outstanding -> outputs clear immediately, outstanding=0, rr_ptr restarts at 0.
